// File: rtl/note_period_sequencer.sv
// Key-to-half-period selector for the square-wave voice: per-input debounce,
// last-note priority with fallback to held keys, octave shift, sample-aligned output.

module debounce_cell #(
  parameter int CYCLES = 12288
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic state
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= 1'b0;
      cnt   <= '0;
    end else if (level != state) begin
      if (cnt == CW'(CYCLES - 1)) begin
        state <= level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end
endmodule

module note_period_sequencer #(
  parameter int NUM_KEYS        = 12,
  parameter int PERIOD_W        = 10,
  parameter int DEBOUNCE_CYCLES = 12288,
  parameter int OCT_MAX         = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                oct_up,
  input  logic                oct_down,
  input  logic                sample_tick,
  output logic [PERIOD_W-1:0] current_half_period,
  output logic                note_active,
  output logic signed [2:0]   octave,
  output logic                test_LED_R
);
  localparam int NUM_IN = NUM_KEYS + 2;
  localparam int IDX_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [31:0]       PMAX = (32'd1 << PERIOD_W) - 32'd1;
  localparam logic signed [2:0] OMAX = 3'(OCT_MAX);
  localparam logic signed [2:0] OMIN = -3'(OCT_MAX);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } sel_t;

  logic [NUM_IN-1:0]   raw, db, db_d, rise;
  logic [NUM_KEYS-1:0] key_rise, key_fall, key_held;
  logic                up_edge, dn_edge;
  logic                rise_any, held_any;
  logic [IDX_W-1:0]    rise_idx, held_idx;
  sel_t                sel_q, sel_d;
  logic [2:0]          mag;
  logic [31:0]         base_w, shifted;
  logic [PERIOD_W-1:0] period_next;

  // Buttons ride along with the keys through the same debounce lanes.
  assign raw = {oct_down, oct_up, keys};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_db
    debounce_cell #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .level (raw[i]),
      .state (db[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) db_d <= '0;
    else     db_d <= db;
  end

  assign rise     = db & ~db_d;
  assign key_rise = rise[NUM_KEYS-1:0];
  assign key_held = db[NUM_KEYS-1:0];
  assign key_fall = ~db[NUM_KEYS-1:0] & db_d[NUM_KEYS-1:0];
  assign up_edge  = rise[NUM_KEYS];
  assign dn_edge  = rise[NUM_KEYS+1];

  // Downward scan leaves the lowest set index in each result.
  always_comb begin
    rise_any = 1'b0;
    rise_idx = '0;
    held_any = 1'b0;
    held_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_rise[i]) begin
        rise_any = 1'b1;
        rise_idx = IDX_W'(i);
      end
      if (key_held[i]) begin
        held_any = 1'b1;
        held_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_d = sel_q;
    if (rise_any) begin
      sel_d.valid = 1'b1;
      sel_d.idx   = rise_idx;
    end else if (sel_q.valid && key_fall[sel_q.idx]) begin
      sel_d.valid = held_any;
      sel_d.idx   = held_any ? held_idx : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= '0;
      octave <= '0;
    end else begin
      sel_q <= sel_d;
      if (up_edge && !dn_edge && octave < OMAX)
        octave <= octave + 3'sd1;
      else if (dn_edge && !up_edge && octave > OMIN)
        octave <= octave - 3'sd1;
    end
  end

  function automatic logic [6:0] base_of(input int k);
    logic [6:0] t;
    case (k % 12)
      0:       t = 7'd91;
      1:       t = 7'd86;
      2:       t = 7'd81;
      3:       t = 7'd76;
      4:       t = 7'd72;
      5:       t = 7'd68;
      6:       t = 7'd64;
      7:       t = 7'd60;
      8:       t = 7'd57;
      9:       t = 7'd54;
      10:      t = 7'd51;
      default: t = 7'd48;
    endcase
    return t >> (k / 12);
  endfunction

  // Downward shifts can overflow the output width; clamp at all-ones.
  always_comb begin
    mag     = octave[2] ? 3'(-octave) : 3'(octave);
    base_w  = {25'd0, base_of(int'(sel_q.idx))};
    shifted = octave[2] ? (base_w << mag) : (base_w >> mag);
    if (!sel_q.valid)
      period_next = '0;
    else if (shifted > PMAX)
      period_next = PMAX[PERIOD_W-1:0];
    else
      period_next = shifted[PERIOD_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      current_half_period <= '0;
      note_active         <= 1'b0;
      test_LED_R          <= 1'b1;
    end else if (sample_tick) begin
      current_half_period <= period_next;
      note_active         <= (period_next != '0);
      test_LED_R          <= (period_next == '0);
    end
  end
endmodule

// File: tb/tb_note_period_sequencer.sv
// Bench for note_period_sequencer: directed scenarios plus random key/button
// traffic compared every cycle against a rule-level reference model.
module tb_note_period_sequencer;
  localparam int NK = 24;
  localparam int D  = 4;
  localparam int PW = 10;
  localparam int OM = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] keys = '0;
  logic          oct_up = 1'b0, oct_down = 1'b0, sample_tick = 1'b0;
  logic [PW-1:0] current_half_period;
  logic          note_active, test_LED_R;
  logic signed [2:0] octave;

  note_period_sequencer #(.NUM_KEYS(NK), .PERIOD_W(PW), .DEBOUNCE_CYCLES(D), .OCT_MAX(OM)) dut (
    .clk(clk), .rst(rst), .keys(keys), .oct_up(oct_up), .oct_down(oct_down),
    .sample_tick(sample_tick), .current_half_period(current_half_period),
    .note_active(note_active), .octave(octave), .test_LED_R(test_LED_R)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, phase = 0;

  // Reference model state: stable level and run length of disagreement per input.
  bit mdb[NK+2], mdbd[NK+2];
  int mrun[NK+2];
  int msel = -1, moct = 0, mper = 0;
  int tbl[12] = '{91, 86, 81, 76, 72, 68, 64, 60, 57, 54, 51, 48};

  function automatic int ref_period(input int sel, input int oct);
    int base, p;
    if (sel < 0) return 0;
    base = tbl[sel % 12] / (2 ** (sel / 12));
    if (oct >= 0) p = base / (2 ** oct);
    else begin
      p = base * (2 ** (-oct));
      if (p > 1023) p = 1023;
    end
    return p;
  endfunction

  task automatic model_step();
    bit r[NK+2];
    bit found;
    int nsel;
    bit up, dn;
    for (int i = 0; i < NK; i++) r[i] = keys[i];
    r[NK] = oct_up;
    r[NK+1] = oct_down;
    if (rst) begin
      for (int i = 0; i < NK + 2; i++) begin mdb[i] = 0; mdbd[i] = 0; mrun[i] = 0; end
      msel = -1; moct = 0; mper = 0;
      return;
    end
    if (sample_tick) mper = ref_period(msel, moct);
    nsel = msel;
    found = 0;
    for (int k = 0; k < NK; k++)
      if (!found && mdb[k] && !mdbd[k]) begin nsel = k; found = 1; end
    if (!found && msel >= 0 && !mdb[msel] && mdbd[msel]) begin
      nsel = -1;
      for (int k = NK - 1; k >= 0; k--) if (mdb[k]) nsel = k;
    end
    msel = nsel;
    up = mdb[NK] && !mdbd[NK];
    dn = mdb[NK+1] && !mdbd[NK+1];
    if (up && !dn && moct < OM) moct++;
    else if (dn && !up && moct > -OM) moct--;
    for (int i = 0; i < NK + 2; i++) begin
      mdbd[i] = mdb[i];
      mrun[i] = (r[i] != mdb[i]) ? mrun[i] + 1 : 0;
      if (mrun[i] == D) begin mdb[i] = r[i]; mrun[i] = 0; end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    phase = (phase + 1) % 8;
    sample_tick = (phase == 0);
  endtask

  task automatic pulse(input bit up);
    if (up) oct_up = 1'b1; else oct_down = 1'b1;
    repeat (6) cyc();
    oct_up = 1'b0;
    oct_down = 1'b0;
    repeat (14) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    keys = '1;
    repeat (3) cyc();
    n_checks++;
    if ({current_half_period, note_active, octave, test_LED_R} !== {10'd0, 1'b0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got per=%0d na=%0b oct=%0d led=%0b want 0/0/0/1",
               current_half_period, note_active, octave, test_LED_R);
    end
    keys = '0;
    rst = 1'b0;
    repeat (10) cyc();
    n_checks++;
    if ({current_half_period, test_LED_R} !== {10'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL idle_after_reset: got per=%0d led=%0b want 0/1", current_half_period, test_LED_R);
    end
  endtask

  task automatic test_single_key();
    keys[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_checks++;
      if ({current_half_period, note_active, test_LED_R} !== {10'(mper), mper != 0, mper == 0}) begin
        n_fail++;
        $display("FAIL press_timing cyc%0d: got per=%0d na=%0b led=%0b want per=%0d",
                 i, current_half_period, note_active, test_LED_R, mper);
      end
    end
    n_checks++;
    if ({current_half_period, note_active, test_LED_R} !== {10'd91, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL key0_press: got per=%0d na=%0b led=%0b want 91/1/0",
               current_half_period, note_active, test_LED_R);
    end
    keys[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_checks++;
      if ({current_half_period, note_active, test_LED_R} !== {10'(mper), mper != 0, mper == 0}) begin
        n_fail++;
        $display("FAIL release_timing cyc%0d: got per=%0d want %0d", i, current_half_period, mper);
      end
    end
    n_checks++;
    if ({current_half_period, note_active, test_LED_R} !== {10'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL key0_release: got per=%0d na=%0b led=%0b want 0/0/1",
               current_half_period, note_active, test_LED_R);
    end
  endtask

  task automatic test_priority();
    int exp_v[5] = '{91, 60, 91, 76, 0};
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: keys[0] = 1'b1;
        1: keys[7] = 1'b1;
        2: keys[7] = 1'b0;
        3: begin keys[3] = 1'b1; keys[9] = 1'b1; end
        default: keys = '0;
      endcase
      repeat (20) cyc();
      n_checks++;
      if (current_half_period !== 10'(exp_v[s])) begin
        n_fail++;
        $display("FAIL priority_step%0d: got per=%0d want %0d", s, current_half_period, exp_v[s]);
      end
    end
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 6; r++) begin
      keys[4] = 1'b1;
      repeat (3) cyc();
      keys[4] = 1'b0;
      repeat (3) cyc();
      n_checks++;
      if (current_half_period !== 10'd0 || note_active !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_rep%0d: got per=%0d na=%0b want 0/0", r, current_half_period, note_active);
      end
    end
    repeat (12) cyc();
    n_checks++;
    if (current_half_period !== 10'd0) begin
      n_fail++;
      $display("FAIL bounce_settle: got per=%0d want 0", current_half_period);
    end
  endtask

  task automatic test_octave();
    // direction per step, expected period, expected octave
    bit dir[11]  = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    int ep[11]   = '{108, 216, 216, 108, 54, 27, 13, 13, 27, 54, 108};
    int eo[11]   = '{-1, -2, -2, -1, 0, 1, 2, 2, 1, 0, -1};
    keys[9] = 1'b1;
    repeat (20) cyc();
    n_checks++;
    if (current_half_period !== 10'd54) begin
      n_fail++;
      $display("FAIL a4_base: got per=%0d want 54", current_half_period);
    end
    for (int s = 0; s < 11; s++) begin
      pulse(dir[s]);
      n_checks++;
      if (current_half_period !== 10'(ep[s]) || octave !== 3'(eo[s])) begin
        n_fail++;
        $display("FAIL octave_step%0d: got per=%0d oct=%0d want per=%0d oct=%0d",
                 s, current_half_period, octave, ep[s], eo[s]);
      end
    end
    pulse(1'b1);
    keys = '0;
    repeat (20) cyc();
  endtask

  task automatic test_high_key();
    keys[21] = 1'b1;
    repeat (20) cyc();
    n_checks++;
    if (current_half_period !== 10'd27) begin
      n_fail++;
      $display("FAIL key21: got per=%0d want 27", current_half_period);
    end
    oct_up = 1'b1;
    oct_down = 1'b1;
    repeat (6) cyc();
    oct_up = 1'b0;
    oct_down = 1'b0;
    repeat (14) cyc();
    n_checks++;
    if (octave !== 3'd0 || current_half_period !== 10'd27) begin
      n_fail++;
      $display("FAIL both_buttons: got oct=%0d per=%0d want 0/27", octave, current_half_period);
    end
    keys = '0;
    repeat (20) cyc();
  endtask

  task automatic test_reset_mid();
    keys[0] = 1'b1;
    pulse(1'b1);
    n_checks++;
    if (current_half_period !== 10'd45 || octave !== 3'd1) begin
      n_fail++;
      $display("FAIL pre_reset: got per=%0d oct=%0d want 45/1", current_half_period, octave);
    end
    while (phase != 3) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++;
    if ({current_half_period, note_active, octave, test_LED_R} !== {10'd0, 1'b0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset: got per=%0d na=%0b oct=%0d led=%0b want 0/0/0/1",
               current_half_period, note_active, octave, test_LED_R);
    end
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_checks++;
      if ({current_half_period, note_active, test_LED_R} !== {10'(mper), mper != 0, mper == 0}) begin
        n_fail++;
        $display("FAIL post_reset cyc%0d: got per=%0d want %0d", i, current_half_period, mper);
      end
      if (i == 4) begin
        n_checks++;
        if (current_half_period !== 10'd0) begin
          n_fail++;
          $display("FAIL rebounce: got per=%0d want 0 before fresh debounce", current_half_period);
        end
      end
    end
    n_checks++;
    if (current_half_period !== 10'd91) begin
      n_fail++;
      $display("FAIL reselect_after_reset: got per=%0d want 91", current_half_period);
    end
    keys = '0;
    repeat (20) cyc();
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 2) == 0) keys[$urandom_range(0, NK - 1)] ^= 1'b1;
      oct_up   = ($urandom_range(0, 5) == 0);
      oct_down = ($urandom_range(0, 5) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      hold     = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) begin
        cyc();
        rst = 1'b0;
        n_checks++;
        if ({current_half_period, note_active, octave, test_LED_R} !==
            {10'(mper), mper != 0, 3'(moct), mper == 0}) begin
          n_fail++;
          $display("FAIL random seg%0d: got per=%0d na=%0b oct=%0d led=%0b want per=%0d oct=%0d",
                   seg, current_half_period, note_active, octave, test_LED_R, mper, moct);
        end
      end
    end
    keys = '0;
    oct_up = 1'b0;
    oct_down = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_priority();
    test_bounce();
    test_octave();
    test_high_key();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
